// File: rtl/shift_reg_mem_pkg.sv
// Shared types and constants for the recirculating character store.
// Clear sweep feature: SHIFT_REG_MEM_CLEAR_SWEEP_EN.
package shift_reg_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_DEPTH = 960;

  localparam logic [63:0] BLANK_CHAR = '0;

endpackage

// File: rtl/shift_reg_mem_pos_ctr.sv
// Modulo-DEPTH position counter with a registered wrap pulse.
// Shared with the scan timing logic.
module shift_reg_mem_pos_ctr #(
  parameter int DEPTH = 960,
  parameter int POS_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             mr_n,
  input  logic             shift_en,
  output logic [POS_W-1:0] pos,
  output logic             wrap
);

  localparam logic [POS_W-1:0] LAST = POS_W'(DEPTH - 1);

  logic at_last;

  assign at_last = (pos == LAST);

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      pos  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= shift_en && at_last;
      if (shift_en) begin
        pos <= at_last ? '0 : pos + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/shift_reg_mem.sv
// Recirculating shift-register character store, DEPTH x WIDTH.
// Optional clear sweep: SHIFT_REG_MEM_CLEAR_SWEEP_EN.
module shift_reg_mem
  import shift_reg_mem_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int POS_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             mr_n,
  input  logic             shift_en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
`ifdef SHIFT_REG_MEM_CLEAR_SWEEP_EN
  input  logic             clr_req,
  output logic             clr_busy,
`endif
  output logic             wrap
);

  localparam logic [WIDTH-1:0] BLANK = WIDTH'(BLANK_CHAR);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [WIDTH-1:0] head;

`ifdef SHIFT_REG_MEM_CLEAR_SWEEP_EN
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sweep_state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    head     = load ? d : q;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = SWEEP;
          cnt_nx   = CNT_FULL;
        end
      end
      SWEEP: begin
        head = BLANK;
        if (shift_en) begin
          cnt_nx = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign clr_busy = (state == SWEEP);
`else
  assign head = load ? d : q;
`endif

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= BLANK;
      end
    end else if (shift_en) begin
      stage[0] <= head;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

  shift_reg_mem_pos_ctr #(
    .DEPTH (DEPTH),
    .POS_W (POS_W)
  ) u_pos_ctr (
    .clk      (clk),
    .mr_n     (mr_n),
    .shift_en (shift_en),
    .pos      (pos),
    .wrap     (wrap)
  );

endmodule
